// File: rtl/bmem_port_arbiter_pkg.sv
// bmem_port_arbiter_pkg: shared types and defaults for the bmem port arbiter.
package bmem_port_arbiter_pkg;
    localparam int BMEM_BURST_LEN = 4;
    localparam int BMEM_NUM_PORTS = 4;
    typedef enum logic {ARB_IDLE, ARB_WBURST} arb_state_t;
    typedef logic [$clog2(BMEM_NUM_PORTS)-1:0] port_id_t;
endpackage

// File: rtl/bmem_port_arbiter_port_id_fifo.sv
// port_id_fifo: synchronous FIFO of port ids for in-order read-response routing.
module port_id_fifo
    import bmem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(port_id_t),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign head    = mem[rp];
    assign do_pop  = pop & ~empty;
    // a push at full is only legal when the same cycle frees a slot
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/bmem_port_arbiter.sv
// bmem_port_arbiter: round-robin N-port burst arbiter in front of a single bmem.
module bmem_port_arbiter
    import bmem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int BURST_LEN       = BMEM_BURST_LEN,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*ADDR_W-1:0]   cli_addr,
    input  logic [NUM_PORTS-1:0]          cli_read,
    input  logic [NUM_PORTS-1:0]          cli_write,
    input  logic [NUM_PORTS*64-1:0]       cli_wdata,
    output logic [NUM_PORTS-1:0]          cli_ready,
    output logic [ADDR_W-1:0]             cli_raddr,
    output logic [63:0]                   cli_rdata,
    output logic [NUM_PORTS-1:0]          cli_rvalid,
    output logic [ADDR_W-1:0]             bmem_addr,
    output logic                          bmem_read,
    output logic                          bmem_write,
    output logic [63:0]                   bmem_wdata,
    input  logic                          bmem_ready,
    input  logic [ADDR_W-1:0]             bmem_raddr,
    input  logic [63:0]                   bmem_rdata,
    input  logic                          bmem_rvalid,
    output logic                          resp_err
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t           state;
    logic [IW-1:0]        rr_ptr, lock, pick, gsel, head;
    logic [BW-1:0]        wbeat, rbeat;
    logic [NUM_PORTS-1:0] cand, grant;
    logic [CW-1:0]        count;
    logic                 idle, is_wr, active, acc, rd_acc, rv, pop, push, full, empty;

    // first requester at or after ptr: mask the doubled vector, take lowest set bit
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [IW-1:0] ptr);
        logic [2*NUM_PORTS-1:0] m;
        logic [IW-1:0]          r;
        m = {req, req} & ({(2*NUM_PORTS){1'b1}} << ptr);
        r = '0;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--)
            if (m[i]) r = IW'(i % NUM_PORTS);
        return r;
    endfunction

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return (p == IW'(NUM_PORTS-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cand   = cli_write | (cli_read & {NUM_PORTS{count < CW'(MAX_OUTSTANDING)}});
        pick   = rr_pick(cand, rr_ptr);
        idle   = state == ARB_IDLE;
        gsel   = idle ? pick : lock;
        is_wr  = cli_write[gsel];
        active = ~rst & (idle ? |cand : is_wr);
        grant  = active ? (NUM_PORTS'(1) << gsel) : '0;
        acc    = active & bmem_ready;
        rd_acc = acc & idle & ~is_wr;
        rv     = ~rst & bmem_rvalid & ~empty;
        pop    = rv & (rbeat == BW'(BURST_LEN-1));
        push   = rd_acc & (~full | pop);
    end

    // outputs are forced low while reset is asserted, independent of the clock
    assign cli_ready  = grant & {NUM_PORTS{bmem_ready}};
    assign bmem_read  = active & idle & ~is_wr;
    assign bmem_write = active & is_wr;
    assign bmem_addr  = rst ? '0 : cli_addr[gsel*ADDR_W +: ADDR_W];
    assign bmem_wdata = rst ? '0 : cli_wdata[gsel*64 +: 64];
    assign cli_rvalid = rv ? (NUM_PORTS'(1) << head) : '0;
    assign cli_raddr  = rst ? '0 : bmem_raddr;
    assign cli_rdata  = rst ? '0 : bmem_rdata;

    port_id_fifo #(.DEPTH(MAX_OUTSTANDING), .W(IW), .CW(CW)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pick),
        .head(head), .full(full), .empty(empty), .count(count)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            lock     <= '0;
            wbeat    <= '0;
            rbeat    <= '0;
            resp_err <= 1'b0;
        end else begin
            if (acc && idle) begin
                if (is_wr) begin
                    state <= ARB_WBURST;
                    lock  <= pick;
                    wbeat <= BW'(1);
                end else
                    rr_ptr <= nxt(pick);
            end else if (acc) begin
                wbeat <= wbeat + 1'b1;
                if (wbeat == BW'(BURST_LEN-1)) begin
                    state  <= ARB_IDLE;
                    rr_ptr <= nxt(lock);
                end
            end
            if (rv) rbeat <= pop ? '0 : rbeat + 1'b1;
            if (bmem_rvalid && empty) resp_err <= 1'b1;
        end
endmodule

// File: tb/tb_bmem_port_arbiter.sv
// tb_bmem_port_arbiter: random stimulus checked against a queue-based arbitration model.
module tb_bmem_port_arbiter;
    localparam int N  = 4;
    localparam int BL = 4;
    localparam int MO = 4;
    localparam int AW = 32;

    logic            clk = 0, rst = 1;
    logic [N*AW-1:0] cli_addr = '0;
    logic [N-1:0]    cli_read = '0, cli_write = '0;
    logic [N*64-1:0] cli_wdata = '0;
    logic [N-1:0]    cli_ready, cli_rvalid;
    logic [AW-1:0]   cli_raddr, bmem_addr;
    logic [63:0]     cli_rdata, bmem_wdata;
    logic            bmem_read, bmem_write, resp_err;
    logic            bmem_ready = 0, bmem_rvalid = 0;
    logic [AW-1:0]   bmem_raddr = '0;
    logic [63:0]     bmem_rdata = '0;

    bmem_port_arbiter #(.NUM_PORTS(N), .BURST_LEN(BL), .MAX_OUTSTANDING(MO), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .cli_addr(cli_addr), .cli_read(cli_read), .cli_write(cli_write),
        .cli_wdata(cli_wdata), .cli_ready(cli_ready), .cli_raddr(cli_raddr), .cli_rdata(cli_rdata),
        .cli_rvalid(cli_rvalid), .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
        .bmem_rvalid(bmem_rvalid), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rr, lock, wbeat, rbeat;
    bit err;
    int q[$];

    task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task model_reset();
        rr = 0; lock = -1; wbeat = 0; rbeat = 0; err = 0;
        q.delete();
    endtask

    task check_zero(input string tag);
        chk({tag, "_ready"}, cli_ready, 0);
        chk({tag, "_rvalid"}, cli_rvalid, 0);
        chk({tag, "_bread"}, bmem_read, 0);
        chk({tag, "_bwrite"}, bmem_write, 0);
        chk({tag, "_baddr"}, bmem_addr, 0);
        chk({tag, "_bwdata"}, bmem_wdata, 0);
        chk({tag, "_raddr"}, cli_raddr, 0);
        chk({tag, "_rdata"}, cli_rdata, 0);
        chk({tag, "_err"}, resp_err, 0);
    endtask

    task rand_inputs();
        for (int p = 0; p < N; p++) begin
            cli_addr[p*AW +: AW] = $urandom;
            cli_wdata[p*64 +: 64] = {$urandom, $urandom};
            cli_write[p] = $urandom_range(0, 5) == 0;
            cli_read[p] = $urandom_range(0, 2) == 0;
        end
        bmem_ready  = $urandom_range(0, 3) != 0;
        bmem_rvalid = $urandom_range(0, 2) == 0;
        bmem_raddr  = $urandom;
        bmem_rdata  = {$urandom, $urandom};
    endtask

    // async reset mid-cycle with live requests; outputs must drop without a clock edge
    task reset_check(input string tag);
        @(negedge clk);
        rand_inputs();
        #2 rst = 1;
        #1 check_zero(tag);
        cli_read = '1; cli_write = '1; bmem_ready = 1; bmem_rvalid = 1;
        #1 check_zero({tag, "_held"});
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        cli_read = '0; cli_write = '0; bmem_rvalid = 0;
        model_reset();
    endtask

    task step();
        int g, p;
        bit found, wr;
        @(negedge clk);
        rand_inputs();
        #2;
        found = 0; g = 0;
        if (lock < 0) begin
            for (int k = 0; k < N; k++) begin
                p = (rr + k) % N;
                if (!found && (cli_write[p] || (cli_read[p] && q.size() < MO))) begin
                    found = 1; g = p;
                end
            end
        end else begin
            g = lock; found = cli_write[g];
        end
        wr = found && cli_write[g];
        chk("cli_ready", cli_ready, (found && bmem_ready) ? (1 << g) : 0);
        chk("bmem_read", bmem_read, found && !wr);
        chk("bmem_write", bmem_write, wr);
        if (found) chk("bmem_addr", bmem_addr, cli_addr[g*AW +: AW]);
        if (wr) chk("bmem_wdata", bmem_wdata, cli_wdata[g*64 +: 64]);
        chk("cli_rvalid", cli_rvalid, (bmem_rvalid && q.size() > 0) ? (1 << q[0]) : 0);
        chk("cli_rdata", cli_rdata, bmem_rdata);
        chk("cli_raddr", cli_raddr, bmem_raddr);
        chk("resp_err", resp_err, err);
        @(posedge clk);
        if (bmem_rvalid) begin
            if (q.size() == 0) err = 1;
            else begin
                rbeat++;
                if (rbeat == BL) begin
                    void'(q.pop_front());
                    rbeat = 0;
                end
            end
        end
        if (found && bmem_ready) begin
            if (lock < 0) begin
                if (wr) begin
                    lock = g; wbeat = 1;
                end else begin
                    q.push_back(g); rr = (g + 1) % N;
                end
            end else begin
                wbeat++;
                if (wbeat == BL) begin
                    rr = (lock + 1) % N; lock = -1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        cli_read = '1; cli_write = '1; bmem_ready = 1; bmem_rvalid = 1;
        @(negedge clk);
        #2 check_zero("reset");
        @(negedge clk);
        rst = 0;
        cli_read = '0; cli_write = '0; bmem_rvalid = 0;

        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 700; c++) step();
            reset_check("midrun_rst");
        end

        // write lock, gap, then reset during the burst
        @(negedge clk);
        cli_write = 4'b0010; cli_read = 4'b0000; bmem_ready = 1; bmem_rvalid = 0;
        #2 chk("wlock_first", cli_ready, 4'b0010);
        @(negedge clk);
        cli_write = 4'b0000; cli_read = 4'b0001;
        #2 chk("wlock_gap", cli_ready, 4'b0000);
        @(negedge clk);
        cli_write = 4'b0010;
        #2 chk("wlock_beat2", cli_ready, 4'b0010);
        rst = 1;
        #1 check_zero("wburst_rst");
        @(negedge clk);
        rst = 0;
        cli_write = 4'b0000;
        @(negedge clk);
        #2 chk("post_rst_grant", cli_ready, 4'b0001);
        chk("post_rst_read", bmem_read, 1);
        reset_check("final_rst");

        for (int c = 0; c < 300; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
